// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, functs, ALU codes, mux selects, FSM states.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_ANDN = 3'b100;
    localparam logic [2:0] ALU_ORN  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    // Coarse ALU request from the FSM; the decoder refines FUNCT using the instruction's funct field.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse ALU request plus funct to the 3-bit ALU code; purely combinational, no backpressure.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       illegal_funct
);

    always_comb begin
        alu_control   = ALU_ADD;
        illegal_funct = 1'b0;
        case (aluop)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: illegal_funct = 1'b1;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS core; Moore outputs combinational from the registered state.
// lw 5 / sw,R,addi 4 / beq,j 3 cycles; FETCH, MEMRD and MEMWR stall while mem_ready is low.
module multicycle_controller
    import mips_pkg::*;
#(
    parameter int unsigned USE_MEM_READY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] ALUcontrol,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       PCEn,
    output logic       illegal
);

    state_t     state;
    state_t     next_state;
    logic [1:0] aluop;
    logic       pc_write;
    logic       branch;
    logic       illegal_funct;
    logic       mem_ok;

    assign mem_ok = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = FETCH;
        aluop      = ALUOP_ADD;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REGB;
        PCSrc      = PCSRC_ALU;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        illegal    = 1'b0;

        case (state)
            FETCH: begin
                ALUSrcB    = SRCB_FOUR;
                IRWrite    = mem_ok;
                pc_write   = mem_ok;
                next_state = mem_ok ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = SRCB_IMMSH;
                case (opcode)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECUTE;
                    OP_BEQ:       next_state = BRANCH;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JUMP;
                    default:      illegal    = 1'b1;
                endcase
            end
            MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                next_state = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                IorD       = 1'b1;
                next_state = mem_ok ? MEMWB : MEMRD;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWR: begin
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                next_state = mem_ok ? FETCH : MEMWR;
            end
            EXECUTE: begin
                // An unknown funct is flagged but still written back as an ADD.
                ALUSrcA    = 1'b1;
                aluop      = ALUOP_FUNCT;
                illegal    = illegal_funct;
                next_state = ALUWB;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = 1'b1;
                aluop   = ALUOP_SUB;
                PCSrc   = PCSRC_ALUOUT;
                branch  = 1'b1;
            end
            ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                next_state = ADDIWB;
            end
            ADDIWB:  RegWrite = 1'b1;
            JUMP: begin
                PCSrc    = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            default: next_state = FETCH;
        endcase

        // While reset is held, present quiescent FETCH selects so nothing architectural is written.
        if (reset) begin
            aluop    = ALUOP_ADD;
            ALUSrcA  = 1'b0;
            ALUSrcB  = SRCB_FOUR;
            PCSrc    = PCSRC_ALU;
            IorD     = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            RegDst   = 1'b0;
            MemtoReg = 1'b0;
            pc_write = 1'b0;
            branch   = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign PCEn = pc_write | (branch & zero);

    alu_decoder u_alu_decoder (
        .aluop         (aluop),
        .funct         (funct),
        .alu_control   (ALUcontrol),
        .illegal_funct (illegal_funct)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: per-cycle vector table of inputs and expected control words, plus hand-written stall/reset sequences.
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [2:0] ALUcontrol;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic       IorD;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       PCEn;
    logic       illegal;

    int checks   = 0;
    int failures = 0;

    multicycle_controller #(.USE_MEM_READY(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .ALUcontrol (ALUcontrol),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .IorD       (IorD),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .PCEn       (PCEn),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word: ALUcontrol, ALUSrcA, ALUSrcB, PCSrc, IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, PCEn, illegal
    logic [15:0] act;
    assign act = {ALUcontrol, ALUSrcA, ALUSrcB, PCSrc, IorD, IRWrite, MemWrite,
                  RegWrite, RegDst, MemtoReg, PCEn, illegal};

    localparam logic [15:0] O_FETCH  = 16'b010_0_01_00_0_1_0_0_0_0_1_0;
    localparam logic [15:0] O_FETCHW = 16'b010_0_01_00_0_0_0_0_0_0_0_0;
    localparam logic [15:0] O_RST    = 16'b010_0_01_00_0_0_0_0_0_0_0_0;
    localparam logic [15:0] O_DEC    = 16'b010_0_11_00_0_0_0_0_0_0_0_0;
    localparam logic [15:0] O_DECI   = 16'b010_0_11_00_0_0_0_0_0_0_0_1;
    localparam logic [15:0] O_MADR   = 16'b010_1_10_00_0_0_0_0_0_0_0_0;
    localparam logic [15:0] O_MRD    = 16'b010_0_00_00_1_0_0_0_0_0_0_0;
    localparam logic [15:0] O_MWB    = 16'b010_0_00_00_0_0_0_1_0_1_0_0;
    localparam logic [15:0] O_MWR    = 16'b010_0_00_00_1_0_1_0_0_0_0_0;
    localparam logic [15:0] O_EXSUB  = 16'b110_1_00_00_0_0_0_0_0_0_0_0;
    localparam logic [15:0] O_EXSLT  = 16'b111_1_00_00_0_0_0_0_0_0_0_0;
    localparam logic [15:0] O_EXAND  = 16'b000_1_00_00_0_0_0_0_0_0_0_0;
    localparam logic [15:0] O_EXILL  = 16'b010_1_00_00_0_0_0_0_0_0_0_1;
    localparam logic [15:0] O_ALUWB  = 16'b010_0_00_00_0_0_0_1_1_0_0_0;
    localparam logic [15:0] O_BRT    = 16'b110_1_00_01_0_0_0_0_0_0_1_0;
    localparam logic [15:0] O_BRN    = 16'b110_1_00_01_0_0_0_0_0_0_0_0;
    localparam logic [15:0] O_AEX    = 16'b010_1_10_00_0_0_0_0_0_0_0_0;
    localparam logic [15:0] O_AWB    = 16'b010_0_00_00_0_0_0_1_0_0_0_0;
    localparam logic [15:0] O_JMP    = 16'b010_0_00_10_0_0_0_0_0_0_1_0;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input logic [15:0] e);
        vec_t v;
        v.rst = r; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = e;
        vecs.push_back(v);
    endtask

    // One clock cycle: drive on the falling edge, check 1 time unit later, state advances at the next rising edge.
    task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rdy, input logic [15:0] e, input string name);
        @(negedge clk);
        reset = r; opcode = op; funct = fn; zero = z; mem_ready = rdy;
        #1;
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL %s: control word got %b expected %b", name, act, e);
        end
    endtask

    task automatic check_bit(input logic a, input logic e, input string name);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, a, e);
        end
    endtask

    initial begin
        reset = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;

        add(1, 6'h00, 6'h00, 0, 1, O_RST);
        add(1, 6'h00, 6'h00, 1, 1, O_RST);
        // lw: 5 cycles
        add(0, 6'h23, 6'h00, 0, 1, O_FETCH);
        add(0, 6'h23, 6'h00, 1, 1, O_DEC);
        add(0, 6'h23, 6'h00, 1, 1, O_MADR);
        add(0, 6'h23, 6'h00, 1, 1, O_MRD);
        add(0, 6'h23, 6'h00, 1, 1, O_MWB);
        // R-type sub, slt, and, unknown funct
        add(0, 6'h00, 6'h22, 1, 1, O_FETCH);
        add(0, 6'h00, 6'h22, 1, 1, O_DEC);
        add(0, 6'h00, 6'h22, 1, 1, O_EXSUB);
        add(0, 6'h00, 6'h22, 1, 1, O_ALUWB);
        add(0, 6'h00, 6'h2A, 0, 1, O_FETCH);
        add(0, 6'h00, 6'h2A, 0, 1, O_DEC);
        add(0, 6'h00, 6'h2A, 0, 1, O_EXSLT);
        add(0, 6'h00, 6'h2A, 0, 1, O_ALUWB);
        add(0, 6'h00, 6'h24, 0, 1, O_FETCH);
        add(0, 6'h00, 6'h24, 0, 1, O_DEC);
        add(0, 6'h00, 6'h24, 0, 1, O_EXAND);
        add(0, 6'h00, 6'h24, 0, 1, O_ALUWB);
        add(0, 6'h00, 6'h3F, 0, 1, O_FETCH);
        add(0, 6'h00, 6'h3F, 0, 1, O_DEC);
        add(0, 6'h00, 6'h3F, 0, 1, O_EXILL);
        add(0, 6'h00, 6'h3F, 0, 1, O_ALUWB);
        // beq taken / not taken
        add(0, 6'h04, 6'h00, 0, 1, O_FETCH);
        add(0, 6'h04, 6'h00, 0, 1, O_DEC);
        add(0, 6'h04, 6'h00, 1, 1, O_BRT);
        add(0, 6'h04, 6'h00, 1, 1, O_FETCH);
        add(0, 6'h04, 6'h00, 1, 1, O_DEC);
        add(0, 6'h04, 6'h00, 0, 1, O_BRN);
        // j
        add(0, 6'h02, 6'h00, 0, 1, O_FETCH);
        add(0, 6'h02, 6'h00, 0, 1, O_DEC);
        add(0, 6'h02, 6'h00, 0, 1, O_JMP);
        // addi
        add(0, 6'h08, 6'h00, 1, 1, O_FETCH);
        add(0, 6'h08, 6'h00, 1, 1, O_DEC);
        add(0, 6'h08, 6'h00, 1, 1, O_AEX);
        add(0, 6'h08, 6'h00, 1, 1, O_AWB);
        // illegal opcode, then fetch stalls on memory, then a j
        add(0, 6'h3F, 6'h00, 0, 1, O_FETCH);
        add(0, 6'h3F, 6'h00, 0, 1, O_DECI);
        add(0, 6'h02, 6'h00, 1, 0, O_FETCHW);
        add(0, 6'h02, 6'h00, 1, 0, O_FETCHW);
        add(0, 6'h02, 6'h00, 0, 1, O_FETCH);
        add(0, 6'h02, 6'h00, 0, 1, O_DEC);
        add(0, 6'h02, 6'h00, 0, 1, O_JMP);
        add(0, 6'h00, 6'h00, 0, 1, O_FETCH);

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].rst, vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].rdy, vecs[i].exp,
                 $sformatf("vec%0d", i));

        // sw with memory stalled for 3 cycles in MEMWR (now in DECODE after the last table row)
        step(0, 6'h2B, 6'h00, 0, 1, O_DEC,  "sw_decode");
        step(0, 6'h2B, 6'h00, 0, 1, O_MADR, "sw_memadr");
        for (int i = 0; i < 3; i++) begin
            step(0, 6'h2B, 6'h00, 1, 0, O_MWR, $sformatf("sw_wait%0d", i));
            check_bit(MemWrite, 1'b1, $sformatf("sw_memwrite_held%0d", i));
        end
        step(0, 6'h2B, 6'h00, 0, 1, O_MWR,   "sw_done");
        step(0, 6'h2B, 6'h00, 0, 0, O_FETCHW, "sw_back_to_fetch");

        // lw with a MEMRD stall, then reset held for 2 cycles while in MEMWB
        step(0, 6'h23, 6'h00, 0, 1, O_FETCH, "lw2_fetch");
        step(0, 6'h23, 6'h00, 0, 1, O_DEC,   "lw2_decode");
        step(0, 6'h23, 6'h00, 0, 1, O_MADR,  "lw2_memadr");
        step(0, 6'h23, 6'h00, 0, 0, O_MRD,   "lw2_memrd_wait");
        step(0, 6'h23, 6'h00, 0, 1, O_MRD,   "lw2_memrd");
        step(0, 6'h23, 6'h00, 0, 1, O_MWB,   "lw2_memwb");
        for (int i = 0; i < 2; i++) begin
            step(1, 6'h23, 6'h00, 1, 1, O_RST, $sformatf("rst_in_memwb%0d", i));
            check_bit(RegWrite, 1'b0, $sformatf("rst_regwrite%0d", i));
            check_bit(PCEn, 1'b0, $sformatf("rst_pcen%0d", i));
        end
        step(0, 6'h02, 6'h00, 0, 1, O_FETCH, "post_rst_fetch");
        step(0, 6'h02, 6'h00, 0, 1, O_DEC,   "post_rst_decode");
        step(0, 6'h02, 6'h00, 0, 1, O_JMP,   "post_rst_jump");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
